hwce_tcdm_g_arbiter: RTL

- Round-robin arbiter that shares one grouped (4-lane, 4*DATA_WIDTH) TCDM master port among N_REQ HWCE grouped requesters (e.g. weight, x-in, y-in, y-out streams).
- Arbitration is combinational. Response routing is in-order, via an outstanding-requester-ID FIFO.
- Sits between the HWCE stream engines and the grouped-master adapter that splits the wide port into four 32-bit TCDM lanes.

---
 rtl/hwce_garb_pkg.sv | 32 +++
 rtl/hwce_garb_id_fifo.sv | 45 ++++
 rtl/hwce_tcdm_g_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/hwce_garb_pkg.sv
// Shared types and the round-robin pick helper for the HWCE grouped TCDM arbiter.
// The optional burst-lock feature of the arbiter is enabled with HWCE_GARB_LOCK_EN.
package hwce_garb_pkg;

  localparam int NLANES       = 4;
  localparam int GARB_MAX_REQ = 8;

  typedef logic [$clog2(GARB_MAX_REQ)-1:0] req_id_t;

  typedef struct packed {
    logic    found;
    req_id_t idx;
  } pick_t;

  // First set bit of req at or after ptr, wrapping at nReq.
  function automatic pick_t rr_pick(input logic [GARB_MAX_REQ-1:0] req,
                                    input req_id_t ptr,
                                    input int unsigned nReq = GARB_MAX_REQ);
    pick_t       res;
    int unsigned cand;
    res = '0;
    for (int unsigned i = 0; i < GARB_MAX_REQ; i++) begin
      cand = (32'(ptr) + i) % nReq;
      if (!res.found && (i < nReq) && req[req_id_t'(cand)]) begin
        res.found = 1'b1;
        res.idx   = req_id_t'(cand);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/hwce_garb_id_fifo.sv
// In-order FIFO of granted requester IDs; the extra pointer MSB separates full from empty.
module hwce_garb_id_fifo
  import hwce_garb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  req_id_t                  data_i,
  input  logic                     pop_i,
  output req_id_t                  data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH) + 1;

  req_id_t         mem_q [DEPTH];
  logic [PW-1:0]   wPtr_q, rPtr_q;
  logic            doPush, doPop;

  assign empty_o = (wPtr_q == rPtr_q);
  assign full_o  = (wPtr_q[PW-1] != rPtr_q[PW-1]) && (wPtr_q[PW-2:0] == rPtr_q[PW-2:0]);
  assign count_o = wPtr_q - rPtr_q;
  assign data_o  = mem_q[rPtr_q[PW-2:0]];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wPtr_q[PW-2:0]] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr_q <= '0;
      rPtr_q <= '0;
    end else begin
      if (doPush) wPtr_q <= wPtr_q + PW'(1);
      if (doPop)  rPtr_q <= rPtr_q + PW'(1);
    end
  end

endmodule

// File: rtl/hwce_tcdm_g_arbiter.sv
// Round-robin arbiter sharing one 4-lane grouped TCDM master port among N_REQ requesters.
// Define HWCE_GARB_LOCK_EN to let a requester hold the port for a locked burst.
module hwce_tcdm_g_arbiter
  import hwce_garb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_OUTST  = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [N_REQ-1:0]                            req_i,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]            add_i,
  input  logic [N_REQ-1:0]                            wen_i,
  input  logic [N_REQ-1:0][NLANES*DATA_WIDTH-1:0]     wdata_i,
  input  logic [N_REQ-1:0][NLANES*BE_WIDTH-1:0]       be_i,
  output logic [N_REQ-1:0]                            gnt_o,
  output logic [N_REQ-1:0]                            r_valid_o,
  output logic [NLANES*DATA_WIDTH-1:0]                r_rdata_o,
  output logic                                        m_req_o,
  output logic [ADDR_WIDTH-1:0]                       m_add_o,
  output logic                                        m_wen_o,
  output logic [NLANES*DATA_WIDTH-1:0]                m_wdata_o,
  output logic [NLANES*BE_WIDTH-1:0]                  m_be_o,
  input  logic                                        m_gnt_i,
  input  logic                                        m_r_valid_i,
  input  logic [NLANES*DATA_WIDTH-1:0]                m_r_rdata_i,
  input  logic [N_REQ-1:0]                            lock_i,
  output logic [$clog2(MAX_OUTST):0]                  outst_o,
  output logic                                        err_o
);

  logic [GARB_MAX_REQ-1:0] reqWide, reqEff;
  pick_t                   pick;
  req_id_t                 rrPtr_q, rrPtr_d, selId, headId;
  logic                    fifoFull, fifoEmpty, handshake, pop, err_q;

  function automatic req_id_t incPtr(input req_id_t p);
    return (p == req_id_t'(N_REQ - 1)) ? '0 : p + req_id_t'(1);
  endfunction

  assign reqWide = GARB_MAX_REQ'(req_i);

`ifdef HWCE_GARB_LOCK_EN
  logic [GARB_MAX_REQ-1:0] lockWide;
  logic                    locked_q, locked_d, lockHeld;
  req_id_t                 lockOwner_q, lockOwner_d;

  assign lockWide = GARB_MAX_REQ'(lock_i);
  // A dropped request from the owner releases the lock in the same cycle.
  assign lockHeld = locked_q && reqWide[lockOwner_q];

  always_comb begin
    reqEff = reqWide;
    if (lockHeld) begin
      reqEff              = '0;
      reqEff[lockOwner_q] = 1'b1;
    end
  end
`else
  logic unusedLock;
  assign unusedLock = ^lock_i;
  assign reqEff     = reqWide;
`endif

  assign pick      = rr_pick(reqEff, rrPtr_q, N_REQ);
  assign m_req_o   = !rst && pick.found && !fifoFull;
  assign handshake = m_req_o && m_gnt_i;
  assign pop       = !rst && m_r_valid_i && !fifoEmpty;
  assign selId     = m_req_o ? pick.idx : rrPtr_q;
  assign r_rdata_o = m_r_rdata_i;
  assign err_o     = err_q;

  always_comb begin
    m_add_o   = add_i[0];
    m_wen_o   = wen_i[0];
    m_wdata_o = wdata_i[0];
    m_be_o    = be_i[0];
    gnt_o     = '0;
    r_valid_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (selId == req_id_t'(i)) begin
        m_add_o   = add_i[i];
        m_wen_o   = wen_i[i];
        m_wdata_o = wdata_i[i];
        m_be_o    = be_i[i];
      end
      gnt_o[i]     = handshake && (pick.idx == req_id_t'(i));
      r_valid_o[i] = pop && (headId == req_id_t'(i));
    end
  end

  always_comb begin
    rrPtr_d = rrPtr_q;
`ifdef HWCE_GARB_LOCK_EN
    locked_d    = locked_q;
    lockOwner_d = lockOwner_q;
    // The pointer only moves past a requester once it gives up the port.
    if (handshake) begin
      if (lockWide[pick.idx]) begin
        locked_d    = 1'b1;
        lockOwner_d = pick.idx;
      end else begin
        locked_d = 1'b0;
        rrPtr_d  = incPtr(pick.idx);
      end
    end else if (locked_q && !reqWide[lockOwner_q]) begin
      locked_d = 1'b0;
      rrPtr_d  = incPtr(lockOwner_q);
    end
`else
    if (handshake) rrPtr_d = incPtr(pick.idx);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rrPtr_q <= '0;
      err_q   <= 1'b0;
`ifdef HWCE_GARB_LOCK_EN
      locked_q    <= 1'b0;
      lockOwner_q <= '0;
`endif
    end else begin
      rrPtr_q <= rrPtr_d;
      err_q   <= err_q || (m_r_valid_i && fifoEmpty);
`ifdef HWCE_GARB_LOCK_EN
      locked_q    <= locked_d;
      lockOwner_q <= lockOwner_d;
`endif
    end
  end

  hwce_garb_id_fifo #(
    .DEPTH (MAX_OUTST)
  ) i_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (handshake),
    .data_i  (pick.idx),
    .pop_i   (pop),
    .data_o  (headId),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (outst_o)
  );

endmodule
